// File: rtl/amber_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package amber_pkg;

  localparam int unsigned WB_DAT_W = 128;
  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_SEL_W = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntM0 = 2'd1,
    StGntM1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnM0 = 1'b0,
    OwnM1 = 1'b1
  } owner_e;

  function automatic logic [1:0] grant_of(arb_state_e st);
    logic [1:0] g;
    case (st)
      StGntM0: g = 2'b01;
      StGntM1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts consecutive stalled strobe cycles and flags the cycle that reaches TIMEOUT.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stall,
  output logic o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_timeout = i_stall && (cnt_q == CntW'(TIMEOUT - 1));

  // Any non-stalled cycle (response, stb low, no grant) restarts the count.
  always_comb begin
    cnt_d = '0;
    if (i_stall && !o_timeout) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin on ties, grant held for the owner's cycle,
// synthetic error after TIMEOUT stalled strobe cycles.
module wb_arbiter2
  import amber_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic [WB_ADR_W-1:0] i_m0_adr,
  input  logic [WB_SEL_W-1:0] i_m0_sel,
  input  logic                i_m0_we,
  input  logic [WB_DAT_W-1:0] i_m0_dat,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  output logic [WB_DAT_W-1:0] o_m0_dat,
  output logic                o_m0_ack,
  output logic                o_m0_err,

  input  logic [WB_ADR_W-1:0] i_m1_adr,
  input  logic [WB_SEL_W-1:0] i_m1_sel,
  input  logic                i_m1_we,
  input  logic [WB_DAT_W-1:0] i_m1_dat,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  output logic [WB_DAT_W-1:0] o_m1_dat,
  output logic                o_m1_ack,
  output logic                o_m1_err,

  output logic [WB_ADR_W-1:0] o_wb_adr,
  output logic [WB_SEL_W-1:0] o_wb_sel,
  output logic                o_wb_we,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  input  logic                i_wb_ack,
  input  logic                i_wb_err,

  output logic [1:0]          o_grant,
  output logic                o_timeout
);

  arb_state_e state_q, state_d;
  owner_e     last_q, last_d;

  logic req0, req1;
  logic owner_stb, stall, timeout;

  assign req0 = i_m0_cyc & i_m0_stb;
  assign req1 = i_m1_cyc & i_m1_stb;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the master that did not own the bus last time wins.
        if (req0 && (!req1 || last_q == OwnM1)) begin
          state_d = StGntM0;
          last_d  = OwnM0;
        end else if (req1) begin
          state_d = StGntM1;
          last_d  = OwnM1;
        end
      end
      StGntM0: if (!i_m0_cyc) state_d = StIdle;
      StGntM1: if (!i_m1_cyc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      last_q  <= OwnM1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign owner_stb = ((state_q == StGntM0) & i_m0_stb) | ((state_q == StGntM1) & i_m1_stb);
  assign stall     = owner_stb & ~i_wb_ack & ~i_wb_err;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_stall   (stall),
    .o_timeout (timeout)
  );

  assign o_grant   = grant_of(state_q);
  assign o_timeout = timeout;

  always_comb begin
    o_wb_adr = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_dat = '0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    unique case (state_q)
      StGntM0: begin
        o_wb_adr = i_m0_adr;
        o_wb_sel = i_m0_sel;
        o_wb_we  = i_m0_we;
        o_wb_cyc = i_m0_cyc;
        o_wb_stb = i_m0_stb;
        o_wb_dat = i_m0_dat;
        o_m0_dat = i_wb_dat;
        o_m0_ack = i_wb_ack & ~i_wb_err;
        o_m0_err = i_wb_err | timeout;
      end
      StGntM1: begin
        o_wb_adr = i_m1_adr;
        o_wb_sel = i_m1_sel;
        o_wb_we  = i_m1_we;
        o_wb_cyc = i_m1_cyc;
        o_wb_stb = i_m1_stb;
        o_wb_dat = i_m1_dat;
        o_m1_dat = i_wb_dat;
        o_m1_ack = i_wb_ack & ~i_wb_err;
        o_m1_err = i_wb_err | timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus randomized traffic against a
// transaction-level model of ownership, tie-breaking and stall timeout.
module tb_wb_arbiter2;

  localparam int TIMEOUT = 16;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [31:0]  i_m0_adr, i_m1_adr;
  logic [15:0]  i_m0_sel, i_m1_sel;
  logic         i_m0_we, i_m1_we, i_m0_cyc, i_m1_cyc, i_m0_stb, i_m1_stb;
  logic [127:0] i_m0_dat, i_m1_dat;
  logic [127:0] o_m0_dat, o_m1_dat;
  logic         o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [31:0]  o_wb_adr;
  logic [15:0]  o_wb_sel;
  logic         o_wb_we, o_wb_cyc, o_wb_stb;
  logic [127:0] o_wb_dat;
  logic [127:0] i_wb_dat;
  logic         i_wb_ack, i_wb_err;
  logic [1:0]   o_grant;
  logic         o_timeout;

  wb_arbiter2 #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_adr(i_m0_adr), .i_m0_sel(i_m0_sel), .i_m0_we(i_m0_we), .i_m0_dat(i_m0_dat),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(i_m1_adr), .i_m1_sel(i_m1_sel), .i_m1_we(i_m1_we), .i_m1_dat(i_m1_dat),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .o_wb_stb(o_wb_stb), .o_wb_dat(o_wb_dat),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus (0 none, 1 M0, 2 M1), who owned it last,
  // and how many stalled strobe cycles the owner has accumulated.
  int m_owner, m_last, m_stall;
  int silent_left;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit model_stalled();
    bit s;
    s = (m_owner == 1 && i_m0_stb) || (m_owner == 2 && i_m1_stb);
    return s && !i_wb_ack && !i_wb_err;
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_stall = 0;
  endtask

  task automatic eval();
    logic [1:0]   eg;
    logic [178:0] ebus;
    logic [129:0] ersp, e0, e1;
    logic         to;
    #1;
    eg   = 2'b00;
    ebus = '0;
    e0   = '0;
    e1   = '0;
    to   = model_stalled() && (m_stall + 1 == TIMEOUT);
    ersp = {i_wb_dat, i_wb_ack & ~i_wb_err, i_wb_err | to};
    if (m_owner == 1) begin
      eg   = 2'b01;
      ebus = {i_m0_adr, i_m0_sel, i_m0_we, i_m0_cyc, i_m0_stb, i_m0_dat};
      e0   = ersp;
    end else if (m_owner == 2) begin
      eg   = 2'b10;
      ebus = {i_m1_adr, i_m1_sel, i_m1_we, i_m1_cyc, i_m1_stb, i_m1_dat};
      e1   = ersp;
    end
    check_eq("grant", 256'(o_grant), 256'(eg));
    check_eq("wb_bus", 256'({o_wb_adr, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb, o_wb_dat}),
             256'(ebus));
    check_eq("m0_rsp", 256'({o_m0_dat, o_m0_ack, o_m0_err}), 256'(e0));
    check_eq("m1_rsp", 256'({o_m1_dat, o_m1_ack, o_m1_err}), 256'(e1));
    check_eq("timeout", 256'(o_timeout), 256'(to));
  endtask

  task automatic advance();
    bit st, ocyc;
    @(posedge i_clk);
    if (m_owner != 0) begin
      st = model_stalled();
      if (!st) m_stall = 0;
      else if (m_stall + 1 == TIMEOUT) m_stall = 0;
      else m_stall++;
      ocyc = (m_owner == 1) ? i_m0_cyc : i_m1_cyc;
      if (!ocyc) begin
        m_owner = 0;
        m_stall = 0;
      end
    end else begin
      if ((i_m0_cyc && i_m0_stb) && (i_m1_cyc && i_m1_stb)) m_owner = (m_last == 2) ? 1 : 2;
      else if (i_m0_cyc && i_m0_stb) m_owner = 1;
      else if (i_m1_cyc && i_m1_stb) m_owner = 2;
      if (m_owner != 0) m_last = m_owner;
      m_stall = 0;
    end
    @(negedge i_clk);
  endtask

  task automatic tick();
    eval();
    advance();
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr);
    if (m == 0) begin
      i_m0_cyc = cyc; i_m0_stb = stb; i_m0_we = we; i_m0_adr = adr;
      i_m0_sel = 16'($urandom()); i_m0_dat = rnd128();
    end else begin
      i_m1_cyc = cyc; i_m1_stb = stb; i_m1_we = we; i_m1_adr = adr;
      i_m1_sel = 16'($urandom()); i_m1_dat = rnd128();
    end
  endtask

  task automatic set_slv(input logic ack, input logic err, input logic [127:0] dat);
    i_wb_ack = ack;
    i_wb_err = err;
    i_wb_dat = dat;
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_slv(1'b0, 1'b0, 128'h0);
    tick();
    tick();
  endtask

  // Asserts reset between clock edges and expects every output to drop at once.
  task automatic do_reset();
    #2 i_rst = 1'b1;
    #1;
    check_eq("rst_bus", 256'({o_grant, o_timeout, o_wb_adr, o_wb_sel, o_wb_we, o_wb_cyc,
                              o_wb_stb, o_wb_dat}), 256'(0));
    check_eq("rst_m0", 256'({o_m0_dat, o_m0_ack, o_m0_err}), 256'(0));
    check_eq("rst_m1", 256'({o_m1_dat, o_m1_ack, o_m1_err}), 256'(0));
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic rand_master(input int m);
    logic c, s;
    c = (m == 0) ? i_m0_cyc : i_m1_cyc;
    s = (m == 0) ? i_m0_stb : i_m1_stb;
    if ($urandom_range(0, 5) == 0) begin
      c = ~c;
      s = c;
    end else if (c && $urandom_range(0, 7) == 0) begin
      s = ~s;
    end
    set_m(m, c, s, 1'($urandom_range(0, 1)), $urandom());
  endtask

  task automatic rand_slave();
    int r;
    if (silent_left > 0) begin
      silent_left--;
      set_slv(1'b0, 1'b0, rnd128());
    end else begin
      r = $urandom_range(0, 99);
      if (r < 4) silent_left = $urandom_range(18, 24);
      set_slv(r >= 4 && (r < 50 || (r >= 58 && r < 61)), r >= 50 && r < 61, rnd128());
    end
  endtask

  logic [127:0] rd_data;

  initial begin
    i_rst = 1'b1;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_slv(1'b0, 1'b0, 128'h0);
    silent_left = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_eq("rst_grant", 256'(o_grant), 256'(0));
    check_eq("rst_wb_cyc", 256'({o_wb_cyc, o_wb_stb, o_wb_we}), 256'(0));
    i_rst = 1'b0;

    // First tie after reset goes to M0, then M1 after M0 releases, then M0 again.
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h20);
    tick();
    set_slv(1'b1, 1'b0, rnd128());
    eval(); check_eq("tie1_m0", 256'(o_grant), 256'(2'b01)); advance();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_slv(1'b0, 1'b0, 128'h0);
    eval(); check_eq("drop_hold", 256'(o_grant), 256'(2'b01)); advance();
    eval(); check_eq("rearb_idle", 256'(o_grant), 256'(2'b00)); advance();
    eval(); check_eq("rearb_m1", 256'(o_grant), 256'(2'b10)); advance();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h30);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h40);
    tick();
    eval(); check_eq("tie2_m0", 256'(o_grant), 256'(2'b01)); advance();
    idle_all();

    // Single M0 read, slave answers on the second granted cycle.
    rd_data = {4{32'hF0081003}};
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h100);
    tick();
    eval();
    check_eq("rd_grant", 256'(o_grant), 256'(2'b01));
    check_eq("rd_adr", 256'({o_wb_adr, o_wb_we}), 256'({32'h100, 1'b0}));
    advance();
    set_slv(1'b1, 1'b0, rd_data);
    eval();
    check_eq("rd_ack", 256'({o_m0_ack, o_m0_err}), 256'(2'b10));
    check_eq("rd_dat", 256'(o_m0_dat), 256'(rd_data));
    check_eq("rd_m1_quiet", 256'({o_m1_dat, o_m1_ack, o_m1_err}), 256'(0));
    advance();
    idle_all();

    // M1 burst of three acked strobes plus a stb-low gap while M0 waits.
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h200);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h300);
    for (int k = 0; k < 4; k++) begin
      set_m(1, 1'b1, k != 2, 1'b1, 32'h200 + 32'(k));
      set_slv(k != 2, 1'b0, rnd128());
      eval(); check_eq("burst_hold", 256'(o_grant), 256'(2'b10)); advance();
    end
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_slv(1'b0, 1'b0, 128'h0);
    tick();
    eval(); check_eq("burst_idle", 256'(o_grant), 256'(2'b00)); advance();
    eval(); check_eq("burst_m0", 256'(o_grant), 256'(2'b01)); advance();
    idle_all();

    // Silent slave: synthetic error only on the 16th stalled cycle.
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h400);
    tick();
    for (int k = 1; k <= 20; k++) begin
      eval();
      check_eq("to_pulse", 256'(o_timeout), 256'(k == 16));
      check_eq("to_err", 256'(o_m0_err), 256'(k == 16));
      advance();
    end
    set_slv(1'b1, 1'b1, rnd128());
    eval();
    check_eq("ackerr", 256'({o_m0_ack, o_m0_err}), 256'(2'b01));
    advance();
    idle_all();

    // Reset in the middle of an M1 transfer, then a tie must go to M0.
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h500);
    tick();
    tick();
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h600);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h700);
    tick();
    eval(); check_eq("post_rst_tie", 256'(o_grant), 256'(2'b01)); advance();
    idle_all();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      rand_master(0);
      rand_master(1);
      rand_slave();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning cycles a granted strobe may wait for ack/err before a synthetic error.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_m0_adr/i_m1_adr  input  32  master address; i_m0_sel/i_m1_sel  input  16  byte selects; i_m0_we/i_m1_we  input  1  write enable.
REQ-005 i_m0_dat/i_m1_dat  input  128  write data; i_m0_cyc/i_m1_cyc, i_m0_stb/i_m1_stb  input  1  Wishbone cycle/strobe.
REQ-006 o_m0_dat/o_m1_dat  output  128  read data; o_m0_ack/o_m1_ack, o_m0_err/o_m1_err  output  1  per-master termination.
REQ-007 o_wb_adr  output  32; o_wb_sel  output  16; o_wb_we, o_wb_cyc, o_wb_stb  output  1; o_wb_dat  output  128  shared slave bus.
REQ-008 i_wb_dat  input  128; i_wb_ack, i_wb_err  input  1  slave response.
REQ-009 o_grant  output  2  one-hot current owner (bit0=M0, bit1=M1, 00=idle); o_timeout  output  1  one-cycle pulse on synthetic error.

Function
REQ-010 FSM states IDLE, GNT_M0, GNT_M1; a master requests when cyc&stb.
REQ-011 IDLE: single requester -> its GNT state next edge; both requesting -> master not in last_owner register; none -> stay IDLE.
REQ-012 last_owner updates on every grant; reset value M1, so M0 wins first tie.
REQ-013 Arbitration latency 1 cycle: slave bus driven from the cycle after the request is seen.
REQ-014 GNT_Mx: o_wb_* combinationally mirrors master x's adr/sel/we/dat/cyc/stb; in IDLE all o_wb_* are 0.
REQ-015 GNT_Mx: o_mx_dat = i_wb_dat, o_mx_ack = i_wb_ack & ~i_wb_err, o_mx_err = i_wb_err; non-owner sees dat=0, ack=0, err=0.
REQ-016 Grant held while owner's cyc is high (bursts, RMW); owner cyc low at edge -> IDLE; other master re-arbitrated next cycle.
REQ-017 Wait counter (clog2(TIMEOUT)+1 bits) increments each cycle owner stb=1 and i_wb_ack=i_wb_err=0; clears on ack, err, or leaving GNT.
REQ-018 Counter == TIMEOUT-1 with no response -> o_mx_err=1 and o_timeout=1 for exactly that cycle, counter clears, grant unchanged.
REQ-019 Simultaneous i_wb_ack and i_wb_err: err forwarded, ack suppressed.
REQ-020 Slave ack/err arriving while IDLE is dropped; no master sees it.
REQ-021 Owner deasserting stb but holding cyc: grant kept, counter held at 0.

Reset
REQ-022 i_rst asserted: state=IDLE, last_owner=M1, counter=0 immediately, independent of i_clk.
REQ-023 During reset all outputs 0: o_grant=00, o_wb_cyc/stb/we=0, o_wb_adr/sel/dat=0, o_mx_ack/err=0, o_mx_dat=0, o_timeout=0.
REQ-024 Reset mid-transaction abandons the transfer; no ack/err delivered; first post-reset tie goes to M0.

Structure
REQ-025 Shared package (amber_pkg): state enum type, WB_DAT_W=128, WB_ADR_W=32, WB_SEL_W=16.
REQ-026 One sub-module wb_timeout_cnt (counter + compare, TIMEOUT parameter); muxes and FSM in top.

Verification
REQ-027 M0 read adr 0x100, ack after 2 cycles, data 0xF0081003 replicated x4 -> o_grant=01 next cycle, o_m0_ack with that data, M1 outputs 0.
REQ-028 M0 and M1 request same cycle after reset -> M0 granted; after M0 cyc drop, M1 granted; next tie -> M0.
REQ-029 M1 holds cyc over 3 acked strobes while M0 requests -> o_grant stays 10 throughout; M0 granted only after M1 cyc low.
REQ-030 TIMEOUT=16, slave never acks -> o_m0_err and o_timeout high on 16th stalled cycle only, one cycle wide.
REQ-031 i_wb_ack=i_wb_err=1 same cycle -> o_mx_err=1, o_mx_ack=0.
REQ-032 i_rst pulsed mid-cycle between edges during GNT_M1 -> all outputs 0 immediately; after release, tie granted to M0.
